div_unit: RTL

- Iterative radix-2 restoring divider in the EXE stage for DIV/DIVU.
- Drives the busy flag that the ID-stage hazard logic combines with an in-ID divide to stall the front end.
- Writes quotient and remainder toward HI/LO: LO = quotient, HI = remainder.
- One divide in flight at a time; fixed latency unless the optional early-out is compiled in.

---
 rtl/div_if.sv | 24 ++
 rtl/div_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/div_if.sv
// Handshake and data bundle between the EXE stage and the iterative divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output div_start, div_signed, dividend, divisor, cancel,
        input  div_busy, div_done, quotient, remainder
    );

    modport slave (
        input  div_start, div_signed, dividend, divisor, cancel,
        output div_busy, div_done, quotient, remainder
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: LO <= quotient, HI <= remainder.
// Optional DIV_EARLY_OUT_EN skips the iterations when |dividend| < |divisor|.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic             eo_q, eo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic             a_neg_s, b_neg_s;
    logic [WIDTH-1:0] a_abs_s, b_abs_s;
    logic [WIDTH:0]   rem_wide_s, trial_s;
    logic             ge_s;

    // Operand magnitudes and one trial-subtract step on the shifted partial remainder.
    always_comb begin
        a_neg_s    = bus.div_signed & bus.dividend[WIDTH-1];
        b_neg_s    = bus.div_signed & bus.divisor[WIDTH-1];
        a_abs_s    = a_neg_s ? ({WIDTH{1'b0}} - bus.dividend) : bus.dividend;
        b_abs_s    = b_neg_s ? ({WIDTH{1'b0}} - bus.divisor) : bus.divisor;
        rem_wide_s = {prem_q, work_q[WIDTH-1]};
        trial_s    = rem_wide_s - {1'b0, dvs_q};
        ge_s       = (rem_wide_s >= {1'b0, dvs_q});
    end

    // Next-state and datapath control for IDLE/CALC/FIX/DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        work_d  = work_q;
        dvs_d   = dvs_q;
        orig_d  = orig_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        eo_d    = eo_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (bus.cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.div_start) begin
                        work_d  = a_abs_s;
                        dvs_d   = b_abs_s;
                        orig_d  = bus.dividend;
                        qneg_d  = a_neg_s ^ b_neg_s;
                        rneg_d  = a_neg_s;
                        dz_d    = (bus.divisor == {WIDTH{1'b0}});
                        prem_d  = {WIDTH{1'b0}};
                        cnt_d   = CNT_W'(WIDTH - 1);
                        busy_d  = 1'b1;
                        state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
                        // FIX still spends one cycle so the result lands with done.
                        if ((bus.divisor != {WIDTH{1'b0}}) && (a_abs_s < b_abs_s)) begin
                            eo_d    = 1'b1;
                            state_d = S_FIX;
                        end else begin
                            eo_d    = 1'b0;
                        end
`else
                        eo_d    = 1'b0;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    prem_d = ge_s ? trial_s[WIDTH-1:0] : rem_wide_s[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], ge_s};
                    busy_d = 1'b1;
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        state_d = S_CALC;
                    end
                end
                S_FIX: begin
                    if (dz_q) begin
                        quo_d = {WIDTH{1'b1}};
                        rem_d = orig_q;
                    end else if (eo_q) begin
                        quo_d = {WIDTH{1'b0}};
                        rem_d = orig_q;
                    end else begin
                        quo_d = qneg_q ? ({WIDTH{1'b0}} - work_q) : work_q;
                        rem_d = rneg_q ? ({WIDTH{1'b0}} - prem_q) : prem_q;
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            prem_q  <= {WIDTH{1'b0}};
            work_q  <= {WIDTH{1'b0}};
            dvs_q   <= {WIDTH{1'b0}};
            orig_q  <= {WIDTH{1'b0}};
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            eo_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            work_q  <= work_d;
            dvs_q   <= dvs_d;
            orig_q  <= orig_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            eo_q    <= eo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

    assign bus.div_busy  = busy_q;
    assign bus.div_done  = done_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rem_q;
endmodule
